// File: rtl/reset_sequencer_pkg.sv
// Shared types and release-timing helpers for the reset sequencer.
package reset_sequencer_pkg;

   typedef enum logic {
      HOLD = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Counter value at which channel idx is released.
   function automatic int unsigned rel_thresh(input int unsigned idx,
                                              input int unsigned rstdelay,
                                              input int unsigned stagger);
      return rstdelay + idx * stagger;
   endfunction

   // Full sequence length: release edge of the last channel relative to the start edge.
   function automatic int unsigned total_cycles(input int unsigned nchan,
                                                input int unsigned rstdelay,
                                                input int unsigned stagger);
      return rstdelay + 1 + (nchan - 1) * stagger;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software request handshake and reset outputs of the reset sequencer.
interface reset_sequencer_if #(
   parameter int unsigned NCHAN = 4
);
   logic             SW_REQ;
   logic [NCHAN-1:0] SW_MASK;
   logic             SW_ACK;
   logic             BUSY;
   logic [NCHAN-1:0] OUT_RST;

   modport master (
      output SW_REQ,
      output SW_MASK,
      input  SW_ACK,
      input  BUSY,
      input  OUT_RST
   );

   modport slave (
      input  SW_REQ,
      input  SW_MASK,
      output SW_ACK,
      output BUSY,
      output OUT_RST
   );
endinterface

// File: rtl/reset_sequencer.sv
// Per-domain reset sequencer: holds NCHAN resets, releases them in index order,
// and accepts masked software reset requests through a req/ack handshake.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned NCHAN           = 4,
   parameter int unsigned RSTDELAY        = 1,
   parameter int unsigned STAGGER         = 2,
   parameter bit          OUT_ACTIVE_HIGH = 1'b1
) (
   input logic              CLK,
   input logic              IN_RST,
   reset_sequencer_if.slave bus
);

   localparam int unsigned TOTAL      = total_cycles(NCHAN, RSTDELAY, STAGGER);
   localparam int unsigned CNTW       = $clog2(TOTAL + 1);
   localparam logic        RST_ACTIVE = 1'b1;

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [NCHAN-1:0] mask_q, mask_d;
   (* dont_touch = "true" *) logic [NCHAN-1:0] rst_q;
   logic [NCHAN-1:0] rst_d;
   logic             ack_q, ack_d;
   logic [NCHAN-1:0] rel_c;

   // Per-channel release strobe: true on the edge that clears channel i.
   for (genvar i = 0; i < NCHAN; i++) begin : g_rel
      assign rel_c[i] = (cnt_q == CNTW'(rel_thresh(i, RSTDELAY, STAGGER)));
   end

   // Next-state, counter and handshake logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      rst_d   = rst_q;
      ack_d   = 1'b0;
      case (state_q)
         HOLD: begin
            cnt_d = cnt_q + CNTW'(1);
            rst_d = rst_q & mask_q & ~rel_c;
            if (rel_c[NCHAN-1]) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.SW_REQ) begin
               ack_d   = 1'b1;
               mask_d  = bus.SW_MASK;
               rst_d   = bus.SW_MASK;
               cnt_d   = '0;
               state_d = HOLD;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (IN_RST == RST_ACTIVE) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         mask_q  <= '1;
         rst_q   <= '1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         rst_q   <= rst_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.SW_ACK = ack_q;
   assign bus.BUSY   = (state_q == HOLD);

   // Polarity is applied only at the port; internal timing is always active-high.
   if (OUT_ACTIVE_HIGH) begin : g_out_hi
      assign bus.OUT_RST = rst_q;
   end else begin : g_out_lo
      assign bus.OUT_RST = ~rst_q;
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a staggered active-high instance and a
// STAGGER=0 active-low instance, driven from one clock.
module tb_reset_sequencer;
   localparam int TOT_A = 8;  // RSTDELAY=1, STAGGER=2, NCHAN=4
   localparam int TOT_B = 2;  // RSTDELAY=1, STAGGER=0, NCHAN=4

   typedef struct {
      int         e;
      logic       ack;
      logic       busy;
      logic [3:0] out;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   edge_n  = 0;
   int   err_cnt = 0;
   int   chk_cnt = 0;
   int   ka = -1000, kb = -1000;
   logic [3:0] ma = '1, mb = '1;
   exp_t qa[$], qb[$];

   reset_sequencer_if #(.NCHAN(4)) ifa ();
   reset_sequencer_if #(.NCHAN(4)) ifb ();

   reset_sequencer #(.NCHAN(4), .RSTDELAY(1), .STAGGER(2), .OUT_ACTIVE_HIGH(1'b1)) dut_a (
      .CLK(clk), .IN_RST(rst_a), .bus(ifa)
   );
   reset_sequencer #(.NCHAN(4), .RSTDELAY(1), .STAGGER(0), .OUT_ACTIVE_HIGH(1'b0)) dut_b (
      .CLK(clk), .IN_RST(rst_b), .bus(ifb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Channel i is asserted from start edge k until edge k+rd+1+i*st, if selected by m.
   function automatic logic [3:0] exp_rst(int e, int k, logic [3:0] m, int rd, int st);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = m[i] && (e < k + rd + 1 + i * st);
      return r;
   endfunction

   // Reference model: update on the same edge the DUT samples, queue the expectation.
   always @(posedge clk) begin
      exp_t ea, eb;
      edge_n++;
      ea.e = edge_n;
      eb.e = edge_n;
      if (rst_a) begin
         ka = edge_n; ma = '1; ea.ack = 1'b0;
      end else if (edge_n > ka + TOT_A && ifa.SW_REQ) begin
         ka = edge_n; ma = ifa.SW_MASK; ea.ack = 1'b1;
      end else begin
         ea.ack = 1'b0;
      end
      ea.busy = (edge_n < ka + TOT_A);
      ea.out  = exp_rst(edge_n, ka, ma, 1, 2);
      qa.push_back(ea);

      if (rst_b) begin
         kb = edge_n; mb = '1; eb.ack = 1'b0;
      end else if (edge_n > kb + TOT_B && ifb.SW_REQ) begin
         kb = edge_n; mb = ifb.SW_MASK; eb.ack = 1'b1;
      end else begin
         eb.ack = 1'b0;
      end
      eb.busy = (edge_n < kb + TOT_B);
      eb.out  = ~exp_rst(edge_n, kb, mb, 1, 0);
      qb.push_back(eb);
   end

   // Compare on the falling edge, away from the sampling edge.
   always @(negedge clk) begin
      exp_t ea, eb;
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         check($sformatf("a_ack@%0d", ea.e), 32'(ifa.SW_ACK), 32'(ea.ack));
         check($sformatf("a_busy@%0d", ea.e), 32'(ifa.BUSY), 32'(ea.busy));
         check($sformatf("a_out@%0d", ea.e), 32'(ifa.OUT_RST), 32'(ea.out));
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         check($sformatf("b_ack@%0d", eb.e), 32'(ifb.SW_ACK), 32'(eb.ack));
         check($sformatf("b_busy@%0d", eb.e), 32'(ifb.BUSY), 32'(eb.busy));
         check($sformatf("b_out@%0d", eb.e), 32'(ifb.OUT_RST), 32'(eb.out));
      end
      // Fixed timeline points of the power-on and restart sequences.
      case (edge_n)
         5:  check("b_lo_e5",  32'(ifb.OUT_RST), 32'h0);
         7:  check("b_lo_e7",  32'(ifb.OUT_RST), 32'hf);
         10: check("a_pwr_e10", 32'(ifa.OUT_RST), 32'hf);
         12: check("a_pwr_e12", 32'(ifa.OUT_RST), 32'he);
         14: check("a_pwr_e14", 32'(ifa.OUT_RST), 32'hc);
         16: check("a_pwr_e16", 32'(ifa.OUT_RST), 32'h8);
         17: check("a_busy_e17", 32'(ifa.BUSY), 32'h1);
         18: check("a_pwr_e18", 32'(ifa.OUT_RST), 32'h0);
         19: check("a_ack_e19", 32'(ifa.SW_ACK), 32'h1);
         30: check("a_sw_e30", 32'(ifa.OUT_RST), 32'ha);
         35: check("a_rst_e35", 32'(ifa.OUT_RST), 32'hf);
         43: check("a_busy_e43", 32'(ifa.BUSY), 32'h0);
         default: ;
      endcase
   end

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.SW_REQ = 1'b0; ifa.SW_MASK = '0;
      ifb.SW_REQ = 1'b0; ifb.SW_MASK = '0;
      for (int e = 1; e <= 100; e++) begin
         // Inputs set here are sampled at edge e.
         rst_a = (e <= 10) || (e == 35) || (e == 50);
         rst_b = (e <= 5);
         case (e)
            13: begin ifa.SW_REQ = 1'b1; ifa.SW_MASK = 4'b1010; end
            30: begin ifa.SW_REQ = 1'b1; ifa.SW_MASK = 4'b1010; end
            50: begin ifa.SW_REQ = 1'b1; ifa.SW_MASK = 4'b0101; end
            75: begin ifa.SW_REQ = 1'b1; ifa.SW_MASK = 4'b0000; end
            default: ;
         endcase
         if (e == 12) begin ifb.SW_REQ = 1'b1; ifb.SW_MASK = 4'b0110; end
         @(posedge clk);
         #1;
         if (ifa.SW_ACK) ifa.SW_REQ = 1'b0;
         if (ifb.SW_ACK) ifb.SW_REQ = 1'b0;
      end
      #10;
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
